// File: rtl/data_island_packet_receiver.sv
// HDMI data-island receiver: preamble/guard-band framing, TERC4 decode and packet deserialization.
// Define DATA_ISLAND_RX_ECC_CHECK_EN to compile in per-packet BCH syndrome checking.
module data_island_packet_receiver #(
  parameter int PREAMBLE_LENGTH = 8,
  parameter int MAX_PACKETS     = 18
) (
  input  logic        pixelClock,
  input  logic        reset,
  input  logic [9:0]  channel0,
  input  logic [9:0]  channel1,
  input  logic [9:0]  channel2,
  output logic        islandActive,
  output logic        packetValid,
  output logic [23:0] header,
  output logic [55:0] subpacket0,
  output logic [55:0] subpacket1,
  output logic [55:0] subpacket2,
  output logic [55:0] subpacket3,
  output logic        packetIsFirst,
  output logic        headerEccError,
  output logic [3:0]  subpacketEccError,
  output logic        islandError
);

  localparam int CNT_W = $clog2(PREAMBLE_LENGTH + 1);
  localparam int PKT_W = $clog2(MAX_PACKETS + 1);
  localparam logic [CNT_W-1:0] PRE_LEN  = CNT_W'(PREAMBLE_LENGTH);
  localparam logic [9:0]       CODE_PRE = 10'b0010101011;
  localparam logic [9:0]       CODE_GB  = 10'b0100110011;

  typedef enum logic [2:0] {IDLE, PRE_CNT, LEAD_GB, PACKET, PKT_END, TRAIL_GB} state_t;

  function automatic logic [4:0] terc4_decode(input logic [9:0] code);
    logic [4:0] r;
    case (code)
      10'b1010011100: r = 5'h10;
      10'b1001100011: r = 5'h11;
      10'b1011100100: r = 5'h12;
      10'b1011100010: r = 5'h13;
      10'b0101110001: r = 5'h14;
      10'b0100011110: r = 5'h15;
      10'b0110001110: r = 5'h16;
      10'b0100111100: r = 5'h17;
      10'b1011001100: r = 5'h18;
      10'b0100111001: r = 5'h19;
      10'b0110011100: r = 5'h1A;
      10'b1011000110: r = 5'h1B;
      10'b1010001110: r = 5'h1C;
      10'b1001110001: r = 5'h1D;
      10'b0101100011: r = 5'h1E;
      10'b1011000011: r = 5'h1F;
      default:        r = 5'h00;
    endcase
    return r;
  endfunction

  // Channel 0 carries HSYNC/VSYNC in its low nibble bits, which the receiver ignores.
  function automatic logic [2:0] terc4_upper(input logic [9:0] code);
    logic [2:0] r;
    case (code)
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010: r = 3'b100;
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100: r = 3'b101;
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110: r = 3'b110;
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011: r = 3'b111;
      default:                                                         r = 3'b000;
    endcase
    return r;
  endfunction

  logic [2:0] t0;
  logic [4:0] t1, t2;
  logic       c0_valid, c0_flag, c0_hdr;
  logic       is_pre, is_gb, is_data;

  assign t0       = terc4_upper(channel0);
  assign t1       = terc4_decode(channel1);
  assign t2       = terc4_decode(channel2);
  assign c0_valid = t0[2];
  assign c0_flag  = t0[1];
  assign c0_hdr   = t0[0];
  assign is_pre   = (channel1 == CODE_PRE) && (channel2 == CODE_PRE);
  assign is_gb    = (channel1 == CODE_GB) && (channel2 == CODE_GB) && c0_valid && c0_flag && c0_hdr;
  assign is_data  = c0_valid && t1[4] && t2[4];

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       chr, chr_nxt;
  logic [PKT_W-1:0] pkt, pkt_nxt;
  logic             first, first_nxt;
  logic             load, emit, abort;

  always_ff @(posedge pixelClock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    chr_nxt   = chr;
    pkt_nxt   = pkt;
    first_nxt = first;
    load      = 1'b0;
    emit      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (is_pre) begin
          state_nxt = PRE_CNT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      PRE_CNT: begin
        if (is_pre) begin
          if (cnt != PRE_LEN) cnt_nxt = cnt + 1'b1;
        end else if (is_gb && cnt >= PRE_LEN) begin
          state_nxt = LEAD_GB;
        end else begin
          state_nxt = IDLE;
        end
      end
      LEAD_GB: begin
        if (is_gb) begin
          state_nxt = PACKET;
          chr_nxt   = 5'd0;
          pkt_nxt   = '0;
          first_nxt = 1'b1;
        end else begin
          abort = 1'b1;
        end
      end
      PACKET: begin
        // Only char 0 of the first packet carries a cleared ch0[3]; later packets enter at chr 1.
        if (is_data && (c0_flag == (chr != 5'd0))) begin
          load    = 1'b1;
          chr_nxt = chr + 5'd1;
          if (chr == 5'd31) begin
            state_nxt = PKT_END;
            emit      = 1'b1;
          end
        end else begin
          abort = 1'b1;
        end
      end
      PKT_END: begin
        if (is_data) begin
          if ((int'(pkt) + 1) < MAX_PACKETS && c0_flag) begin
            load      = 1'b1;
            chr_nxt   = 5'd1;
            pkt_nxt   = pkt + 1'b1;
            first_nxt = 1'b0;
            state_nxt = PACKET;
          end else begin
            abort = 1'b1;
          end
        end else if (is_gb) begin
          state_nxt = TRAIL_GB;
        end else begin
          abort = 1'b1;
        end
      end
      TRAIL_GB: begin
        if (is_gb) state_nxt = IDLE;
        else       abort     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Deserializer: the newest character enters at the top, so char k ends at bit k (header) / 2k (subpacket).
  logic [30:0] hdr_sr;
  logic [31:0] hdr_shift;
  logic [61:0] sp_sr    [4];
  logic [63:0] sp_shift [4];

  always_comb begin
    hdr_shift = {c0_hdr, hdr_sr};
    for (int n = 0; n < 4; n++) sp_shift[n] = {t2[n], t1[n], sp_sr[n]};
  end

  always_ff @(posedge pixelClock) begin
    if (load) begin
      hdr_sr <= hdr_shift[31:1];
      for (int n = 0; n < 4; n++) sp_sr[n] <= sp_shift[n][63:2];
    end
  end

  logic       hdr_ecc_bad;
  logic [3:0] sp_ecc_bad;

`ifdef DATA_ISLAND_RX_ECC_CHECK_EN
  function automatic logic [7:0] bch_step(input logic [7:0] r, input logic b);
    return (r >> 1) ^ ((r[0] ^ b) ? 8'h83 : 8'h00);
  endfunction

  logic [7:0] hdr_syn, hdr_syn_nxt;
  logic [7:0] sp_syn     [4];
  logic [7:0] sp_syn_nxt [4];

  // Header takes one data bit per char (chars 0-23); subpackets take two (chars 0-27), ch1 bit first.
  always_comb begin
    hdr_syn_nxt = (chr == 5'd0) ? 8'h00 : hdr_syn;
    if (chr < 5'd24) hdr_syn_nxt = bch_step(hdr_syn_nxt, c0_hdr);
    for (int n = 0; n < 4; n++) begin
      sp_syn_nxt[n] = (chr == 5'd0) ? 8'h00 : sp_syn[n];
      if (chr < 5'd28) sp_syn_nxt[n] = bch_step(bch_step(sp_syn_nxt[n], t1[n]), t2[n]);
    end
  end

  always_ff @(posedge pixelClock) begin
    if (load) begin
      hdr_syn <= hdr_syn_nxt;
      for (int n = 0; n < 4; n++) sp_syn[n] <= sp_syn_nxt[n];
    end
  end

  always_comb begin
    hdr_ecc_bad = (hdr_syn_nxt != hdr_shift[31:24]);
    for (int n = 0; n < 4; n++) sp_ecc_bad[n] = (sp_syn_nxt[n] != sp_shift[n][63:56]);
  end
`else
  assign hdr_ecc_bad = 1'b0;
  assign sp_ecc_bad  = 4'b0000;
`endif

  always_ff @(posedge pixelClock) begin
    if (reset) begin
      cnt               <= '0;
      chr               <= '0;
      pkt               <= '0;
      first             <= 1'b0;
      islandActive      <= 1'b0;
      packetValid       <= 1'b0;
      islandError       <= 1'b0;
      header            <= '0;
      subpacket0        <= '0;
      subpacket1        <= '0;
      subpacket2        <= '0;
      subpacket3        <= '0;
      packetIsFirst     <= 1'b0;
      headerEccError    <= 1'b0;
      subpacketEccError <= '0;
    end else begin
      cnt          <= cnt_nxt;
      chr          <= chr_nxt;
      pkt          <= pkt_nxt;
      first        <= first_nxt;
      islandActive <= (state_nxt == LEAD_GB) || (state_nxt == PACKET) ||
                      (state_nxt == PKT_END) || (state_nxt == TRAIL_GB);
      packetValid  <= emit;
      islandError  <= abort;
      if (emit) begin
        header            <= hdr_shift[23:0];
        subpacket0        <= sp_shift[0][55:0];
        subpacket1        <= sp_shift[1][55:0];
        subpacket2        <= sp_shift[2][55:0];
        subpacket3        <= sp_shift[3][55:0];
        packetIsFirst     <= first;
        headerEccError    <= hdr_ecc_bad;
        subpacketEccError <= sp_ecc_bad;
      end
    end
  end

endmodule

// File: tb/tb_data_island_packet_receiver.sv
// Randomized scoreboard bench for data_island_packet_receiver: islands are built from packet
// contents, expected strobes/errors are queued by the driver and popped by an output monitor.
module tb_data_island_packet_receiver;

  localparam int PRE_LEN = 8;
  localparam int MAXP    = 18;
  localparam logic [9:0] PRE  = 10'b0010101011;
  localparam logic [9:0] GB   = 10'b0100110011;
  localparam logic [9:0] CTL0 = 10'b1101010100;
  localparam logic [9:0] BAD  = 10'b1111111111;
`ifdef DATA_ISLAND_RX_ECC_CHECK_EN
  localparam bit ECC_EN = 1'b1;
`else
  localparam bit ECC_EN = 1'b0;
`endif

  logic [9:0] terc4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  logic        clk;
  logic        reset;
  logic [9:0]  channel0, channel1, channel2;
  logic        islandActive, packetValid, packetIsFirst, headerEccError, islandError;
  logic [23:0] header;
  logic [55:0] subpacket0, subpacket1, subpacket2, subpacket3;
  logic [3:0]  subpacketEccError;

  data_island_packet_receiver #(.PREAMBLE_LENGTH(PRE_LEN), .MAX_PACKETS(MAXP)) dut (
    .pixelClock(clk), .reset(reset),
    .channel0(channel0), .channel1(channel1), .channel2(channel2),
    .islandActive(islandActive), .packetValid(packetValid), .header(header),
    .subpacket0(subpacket0), .subpacket1(subpacket1), .subpacket2(subpacket2), .subpacket3(subpacket3),
    .packetIsFirst(packetIsFirst), .headerEccError(headerEccError),
    .subpacketEccError(subpacketEccError), .islandError(islandError));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic            is_err;
    logic [31:0]     at;
    logic [23:0]     hdr;
    logic [3:0][55:0] sp;
    logic            first;
    logic            hecc;
    logic [3:0]      secc;
  } ev_t;

  ev_t expq [$];
  ev_t mon_ev;
  int  checks = 0;
  int  errors = 0;

  logic [23:0]      hdr_tab  [20];
  logic [3:0][55:0] sp_tab   [20];
  int               flip_tab [20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // BCH(64,56)/(32,24) parity over the first n data bits, LSB first, G(x)=1+x^6+x^7+x^8.
  function automatic logic [7:0] bch8(input logic [55:0] d, input int n);
    logic [7:0] r;
    logic       fb;
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[7:1]};
      if (fb) r = r ^ 8'h83;
    end
    return r;
  endfunction

  // Output monitor: every strobe must match the next expected event, including its cycle.
  always @(negedge clk) begin
    if (packetValid === 1'b1 || islandError === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_event", {62'd0, packetValid, islandError}, 64'd0);
      end else begin
        mon_ev = expq.pop_front();
        chk("event_cycle", 64'(cyc), 64'(mon_ev.at));
        chk("event_is_error", 64'(islandError), 64'(mon_ev.is_err));
        chk("event_is_packet", 64'(packetValid), 64'(!mon_ev.is_err));
        if (!mon_ev.is_err) begin
          chk("header", 64'(header), 64'(mon_ev.hdr));
          chk("subpacket0", 64'(subpacket0), 64'(mon_ev.sp[0]));
          chk("subpacket1", 64'(subpacket1), 64'(mon_ev.sp[1]));
          chk("subpacket2", 64'(subpacket2), 64'(mon_ev.sp[2]));
          chk("subpacket3", 64'(subpacket3), 64'(mon_ev.sp[3]));
          chk("packet_is_first", 64'(packetIsFirst), 64'(mon_ev.first));
          chk("header_ecc", 64'(headerEccError), 64'(mon_ev.hecc));
          chk("subpacket_ecc", 64'(subpacketEccError), 64'(mon_ev.secc));
        end
      end
    end
  end

  task automatic drive(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    @(negedge clk);
    channel0 = a;
    channel1 = b;
    channel2 = c;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(CTL0, CTL0, CTL0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_active"}, 64'(islandActive), 64'd0);
    chk({tag, "_valid"}, 64'(packetValid), 64'd0);
    chk({tag, "_error"}, 64'(islandError), 64'd0);
    chk({tag, "_header"}, 64'(header), 64'd0);
    chk({tag, "_subpackets"}, 64'(subpacket0 | subpacket1 | subpacket2 | subpacket3), 64'd0);
    chk({tag, "_flags"}, 64'({packetIsFirst, headerEccError, subpacketEccError}), 64'd0);
  endtask

  task automatic fill_tabs();
    for (int i = 0; i < 20; i++) begin
      hdr_tab[i]  = 24'($urandom);
      for (int n = 0; n < 4; n++) sp_tab[i][n] = {24'($urandom), 32'($urandom)};
      flip_tab[i] = -1;
    end
  endtask

  // fkind: 0 none, 1 invalid TERC4 on ch1, 2 wrong ch0[3], 3 reset pulse at that character.
  task automatic send_island(input int npre, input int npkt, input int fpkt, input int fchr, input int fkind);
    bit               ok, stop, fault_here;
    logic [31:0]      h32;
    logic [3:0][63:0] s64;
    logic [3:0]       n0, n1, n2;
    logic [9:0]       c0, c1, c2;
    ev_t              ev;
    ok   = (npre >= PRE_LEN);
    stop = 1'b0;
    for (int i = 0; i < npre; i++) drive(CTL0, PRE, PRE);
    repeat (2) drive(terc4[{2'b11, 2'($urandom)}], GB, GB);
    for (int p = 0; p < npkt && !stop; p++) begin
      h32 = {bch8({32'd0, hdr_tab[p]}, 24), hdr_tab[p]};
      for (int n = 0; n < 4; n++) s64[n] = {bch8(sp_tab[p][n], 56), sp_tab[p][n]};
      if (flip_tab[p] >= 0) h32[flip_tab[p]] = ~h32[flip_tab[p]];
      for (int k = 0; k < 32; k++) begin
        n0 = {(p == 0 && k == 0) ? 1'b0 : 1'b1, h32[k], 2'($urandom)};
        for (int n = 0; n < 4; n++) begin
          n1[n] = s64[n][2*k];
          n2[n] = s64[n][2*k+1];
        end
        c0 = terc4[n0];
        c1 = terc4[n1];
        c2 = terc4[n2];
        fault_here = (p == fpkt) && (k == fchr);
        if (fault_here && fkind == 1) c1 = BAD;
        if (fault_here && fkind == 2) c0 = terc4[n0 ^ 4'b1000];
        if (fault_here && fkind == 3) begin
          drive(c0, c1, c2);
          reset = 1'b1;
          drive(CTL0, CTL0, CTL0);
          reset = 1'b0;
          check_zero("mid_reset");
          stop = 1'b1;
          break;
        end
        drive(c0, c1, c2);
        if (p == 0 && k == 0) chk("island_active_start", 64'(islandActive), 64'(ok));
        if (ok && (p >= MAXP || (fault_here && fkind != 0))) begin
          ev        = '0;
          ev.is_err = 1'b1;
          ev.at     = cyc + 1;
          expq.push_back(ev);
          stop = 1'b1;
          break;
        end
        if (ok && k == 31) begin
          ev        = '0;
          ev.at     = cyc + 1;
          ev.hdr    = h32[23:0];
          ev.first  = (p == 0);
          ev.hecc   = ECC_EN && (bch8({32'd0, h32[23:0]}, 24) != h32[31:24]);
          for (int n = 0; n < 4; n++) begin
            ev.sp[n]   = s64[n][55:0];
            ev.secc[n] = ECC_EN && (bch8(s64[n][55:0], 56) != s64[n][63:56]);
          end
          expq.push_back(ev);
        end
      end
    end
    if (!stop) repeat (2) drive(terc4[{2'b11, 2'($urandom)}], GB, GB);
    drive(CTL0, CTL0, CTL0);
    chk("island_active_end", 64'(islandActive), 64'd0);
    idle(3);
  endtask

  initial begin
    int npkt, fk, fp, fc;
    reset    = 1'b1;
    channel0 = CTL0;
    channel1 = CTL0;
    channel2 = CTL0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    idle(4);

    // General control packet alone.
    fill_tabs();
    hdr_tab[0] = 24'h000003;
    sp_tab[0]  = '0;
    send_island(8, 1, -1, -1, 0);

    // Three back-to-back packets: GCP, AVI, audio.
    fill_tabs();
    hdr_tab[0] = 24'h000003;
    hdr_tab[1] = 24'h0D0282;
    hdr_tab[2] = 24'h0A0184;
    send_island(8, 3, -1, -1, 0);

    // Short preamble is an ordinary control period; a longer one is fine.
    fill_tabs();
    send_island(7, 1, -1, -1, 0);
    send_island(9, 2, -1, -1, 0);

    // Malformed characters inside packets.
    fill_tabs();
    send_island(8, 2, 0, 17, 1);
    send_island(8, 2, 1, 0, 1);
    send_island(8, 1, 0, 0, 2);
    send_island(8, 2, 1, 9, 2);

    // Corrupted header data bit 5 after parity generation.
    fill_tabs();
    flip_tab[0] = 5;
    send_island(8, 1, -1, -1, 0);

    // One packet beyond the per-island limit.
    fill_tabs();
    send_island(8, MAXP + 1, -1, -1, 0);

    // Reset in the middle of the second packet, then a clean island.
    fill_tabs();
    send_island(8, 2, 1, 20, 3);
    fill_tabs();
    send_island(8, 1, -1, -1, 0);

    // Randomized islands with occasional faults.
    repeat (10) begin
      fill_tabs();
      npkt = $urandom_range(1, 4);
      fk   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      fp   = $urandom_range(0, npkt - 1);
      fc   = $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) flip_tab[0] = $urandom_range(0, 31);
      send_island($urandom_range(6, 12), npkt, fp, fc, fk);
    end

    idle(10);
    chk("pending_events", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
